// File: rtl/objram_write_arbiter_if.sv
// objram_write_arbiter_if: requester/object-RAM bundle for the write arbiter.
// slave = arbiter side, master = requester/display side.
interface objram_write_arbiter_if;
   logic        iVS;
   logic        iReq0, iReq1;
   logic [2:0]  iAddr0, iAddr1;
   logic [12:0] iData0, iData1;
   logic        oGnt0, oGnt1;
   logic [2:0]  oObjRam_addr;
   logic [12:0] oObjRam_data;
   logic        oObjRam_we;
   logic        oWin_open;
   logic        oFrame_done;
   logic [7:0]  oMiss_cnt;
   modport slave (
      input  iVS, iReq0, iReq1, iAddr0, iAddr1, iData0, iData1,
      output oGnt0, oGnt1, oObjRam_addr, oObjRam_data, oObjRam_we, oWin_open, oFrame_done, oMiss_cnt
   );
   modport master (
      output iVS, iReq0, iReq1, iAddr0, iAddr1, iData0, iData1,
      input  oGnt0, oGnt1, oObjRam_addr, oObjRam_data, oObjRam_we, oWin_open, oFrame_done, oMiss_cnt
   );
endinterface

// File: rtl/objram_write_arbiter.sv
// objram_write_arbiter: round-robin two-port object RAM write arbiter, gated by a per-frame window.
// Define OBJARB_VSYNC_GATE_EN to open the window on iVS falling; otherwise the window is always open.
module objram_write_arbiter #(
   parameter int WIN_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   objram_write_arbiter_if.slave  bus
);
   logic        w_win, w_en, w_sel1, w_gnt0, w_gnt1;
   logic        r_ptr, r_we;
   logic [2:0]  r_addr;
   logic [12:0] r_data;
`ifdef OBJARB_VSYNC_GATE_EN
   logic        r_vs, r_vs_d, r_win_d, w_done;
   logic [15:0] r_cnt;
   logic [7:0]  r_miss;
   assign w_win  = r_cnt != 16'd0;
   assign w_done = r_win_d & ~w_win;
   // A falling edge while the window is open is ignored: the counter only reloads from zero.
   always_ff @(posedge clk)
      if (reset) begin
         r_vs    <= 1'b1;
         r_vs_d  <= 1'b1;
         r_win_d <= 1'b0;
         r_cnt   <= 16'd0;
         r_miss  <= 8'd0;
      end else begin
         r_vs    <= bus.iVS;
         r_vs_d  <= r_vs;
         r_win_d <= w_win;
         r_cnt   <= w_win ? r_cnt - 16'd1 : (r_vs_d & ~r_vs) ? 16'(WIN_CYCLES) : r_cnt;
         if (w_done & (bus.iReq0 | bus.iReq1) & (r_miss != 8'hFF))
            r_miss <= r_miss + 8'd1;
      end
   assign bus.oFrame_done = w_done;
   assign bus.oMiss_cnt   = r_miss;
`else
   logic [16:0] w_unused;
   assign w_unused        = {bus.iVS, 16'(WIN_CYCLES)};
   assign w_win           = 1'b1;
   assign bus.oFrame_done = 1'b0;
   assign bus.oMiss_cnt   = 8'd0;
`endif
   // r_ptr=1 gives requester 1 priority when both request.
   assign w_en   = w_win & ~reset;
   assign w_sel1 = bus.iReq1 & (~bus.iReq0 | r_ptr);
   assign w_gnt1 = w_en & w_sel1;
   assign w_gnt0 = w_en & bus.iReq0 & ~w_sel1;
   always_ff @(posedge clk)
      if (reset) begin
         r_ptr  <= 1'b0;
         r_we   <= 1'b0;
         r_addr <= 3'd0;
         r_data <= 13'd0;
      end else begin
         r_we <= w_gnt0 | w_gnt1;
         if (w_gnt0 | w_gnt1) begin
            r_ptr  <= w_gnt0;
            r_addr <= w_gnt1 ? bus.iAddr1 : bus.iAddr0;
            r_data <= w_gnt1 ? bus.iData1 : bus.iData0;
         end
      end
   assign bus.oGnt0        = w_gnt0;
   assign bus.oGnt1        = w_gnt1;
   assign bus.oObjRam_we   = r_we;
   assign bus.oObjRam_addr = r_addr;
   assign bus.oObjRam_data = r_data;
   assign bus.oWin_open    = w_win;
endmodule

// File: tb/tb_objram_write_arbiter.sv
// tb_objram_write_arbiter: random requester streams and iVS pulses checked against a frame-level model.
module tb_objram_write_arbiter;
   localparam int WIN = 5;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   objram_write_arbiter_if bus();
   objram_write_arbiter #(.WIN_CYCLES(WIN)) dut (.clk(clk), .reset(reset), .bus(bus));
   int n_chk = 0;
   int n_err = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   int m_left, m_vs, m_vs_d, m_was_open, m_turn, m_we, m_addr, m_data, m_miss;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_left = 0; m_vs = 1; m_vs_d = 1; m_was_open = 0; m_turn = 0;
      m_we = 0; m_addr = 0; m_data = 0; m_miss = 0;
   endtask
   task automatic step(input bit rst, input bit vs, input int p_fill);
      int open, done, g;
      bit r0, r1;
      logic [15:0] w;
      @(negedge clk);
      if ($urandom_range(99) < p_fill) q0.push_back(16'($urandom));
      if ($urandom_range(99) < p_fill) q1.push_back(16'($urandom));
      reset = rst;
      bus.iVS = vs;
      r0 = q0.size() > 0;
      r1 = q1.size() > 0;
      bus.iReq0 = r0;
      bus.iReq1 = r1;
      if (r0) {bus.iAddr0, bus.iData0} = q0[0];
      if (r1) {bus.iAddr1, bus.iData1} = q1[0];
      #1;
`ifdef OBJARB_VSYNC_GATE_EN
      open = int'(m_left > 0);
      done = int'(m_was_open != 0 && open == 0);
`else
      open = 1;
      done = 0;
`endif
      g = -1;
      if (open != 0 && !rst) g = (r0 && r1) ? m_turn : r0 ? 0 : r1 ? 1 : -1;
      if (!rst) begin
         chk("gnt0", 32'(bus.oGnt0), 32'(g == 0));
         chk("gnt1", 32'(bus.oGnt1), 32'(g == 1));
         chk("we", 32'(bus.oObjRam_we), 32'(m_we));
         chk("addr", 32'(bus.oObjRam_addr), 32'(m_addr));
         chk("data", 32'(bus.oObjRam_data), 32'(m_data));
         chk("win_open", 32'(bus.oWin_open), 32'(open));
         chk("frame_done", 32'(bus.oFrame_done), 32'(done));
         chk("miss_cnt", 32'(bus.oMiss_cnt), 32'(m_miss));
      end
      if (rst) model_reset();
      else begin
`ifdef OBJARB_VSYNC_GATE_EN
         if (m_left > 0) m_left--;
         else if (m_vs_d == 1 && m_vs == 0) m_left = WIN;
         m_was_open = open;
         m_vs_d = m_vs;
         m_vs = int'(vs);
         if (done != 0 && (r0 || r1) && m_miss < 255) m_miss++;
`endif
         m_we = int'(g >= 0);
         if (g >= 0) begin
            w = (g == 1) ? q1.pop_front() : q0.pop_front();
            m_addr = int'(w[15:13]);
            m_data = int'(w[12:0]);
            m_turn = 1 - g;
         end
      end
   endtask
   initial begin
      bus.iVS = 1'b1;
      bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
      bus.iAddr0 = '0; bus.iAddr1 = '0;
      bus.iData0 = '0; bus.iData1 = '0;
      model_reset();
      for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 0);
      for (int c = 0; c < 40; c++) step(1'b0, (c % 12) != 2, 100);
      for (int c = 0; c < 2000; c++)
         step($urandom_range(299) == 0, $urandom_range(9) != 0, 40);
      step(1'b1, 1'b1, 0);
      for (int c = 0; c < 2700; c++) step(1'b0, (c % 9) != 0, 100);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/objram_write_arbiter.md
OBJRAM_WRITE_ARBITER -- requirements
Module: objram_write_arbiter

Interface
REQ-001 Parameter WIN_CYCLES, 1024, length in clk cycles of the write window opened per frame (legal range 1..65535).
REQ-002 clk  input  1  pixel clock (CLK_25 domain), all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 iVS  input  1  VGA vertical sync from display driver, active low.
REQ-005 iReq0 / iReq1  input  1 each  requester write valid.
REQ-006 iAddr0 / iAddr1  input  3 each  object RAM word address.
REQ-007 iData0 / iData1  input  13 each  object RAM word data.
REQ-008 oGnt0 / oGnt1  output  1 each  ready; transfer occurs when iReqN and oGntN are both high on a rising edge.
REQ-009 oObjRam_addr  output  3  write address to object RAM.
REQ-010 oObjRam_data  output  13  write data to object RAM.
REQ-011 oObjRam_we  output  1  write enable to object RAM.
REQ-012 oWin_open  output  1  write window active.
REQ-013 oFrame_done  output  1  one-cycle pulse in the cycle after the window closes.
REQ-014 oMiss_cnt  output  8  saturating count of windows that closed with a request pending.

Function
REQ-015 iVS SHALL be registered once; a window-open event is the registered iVS going 1->0.
REQ-016 oWin_open SHALL go high the cycle after the event and remain high exactly WIN_CYCLES cycles, driven by a 16-bit down-counter.
REQ-017 A window-open event while the window is already open SHALL be ignored (counter not reloaded).
REQ-018 oGntN SHALL be combinational: high only when oWin_open is high and the arbiter selects requester N; at most one grant high per cycle.
REQ-019 Arbitration SHALL be round-robin with a 1-bit priority pointer: if only one requester is requesting, it is granted; if both are, the pointed-to requester is granted.
REQ-020 After each transfer from requester N, the pointer SHALL point to the other requester; it is unchanged in cycles with no transfer.
REQ-021 A transfer on edge t SHALL produce oObjRam_we=1 with the captured address/data during cycle t+1 (latency 1); otherwise oObjRam_we=0, and addr/data hold their last values.
REQ-022 A lone requester holding iReq high SHALL transfer one word per cycle while the window is open.
REQ-023 When the window closes mid-stream, grants SHALL drop in the first closed cycle; pending requests wait for the next window with no word lost or duplicated.
REQ-024 oFrame_done SHALL pulse in the first cycle oWin_open is low after being high.
REQ-025 oMiss_cnt SHALL increment on the oFrame_done pulse if iReq0 or iReq1 is high in that cycle, and saturate at 255.
REQ-026 Requesters SHALL hold addr/data stable while iReq is high and not granted; the arbiter does not check this.

Reset
REQ-027 On reset: oGnt0/1=0, oObjRam_we=0, oObjRam_addr=0, oObjRam_data=0, oWin_open=0, oFrame_done=0, oMiss_cnt=0, pointer=requester 0, counter=0, registered iVS=1.
REQ-028 Reset asserted mid-window SHALL close the window immediately without an oFrame_done pulse; any transfer from the reset cycle is discarded.

Configuration
REQ-029 Macro OBJARB_VSYNC_GATE_EN: when defined, grants are gated by the iVS window as above; when undefined, oWin_open is tied high, grants ignore iVS, oFrame_done=0, and oMiss_cnt=0.

Verification
REQ-030 Reset, then pulse iVS low with iReq0=1, addr=3, data=0x1ABC -> oGnt0 rises 2 cycles after the iVS edge; oObjRam_we=1, addr=3, data=0x1ABC on the next cycle.
REQ-031 Both requesting continuously with WIN_CYCLES=8 -> grants alternate 0,1,0,1,0,1,0,1; exactly 8 writes; oFrame_done pulse; oMiss_cnt=1.
REQ-032 Lone iReq1 streaming 5 words with WIN_CYCLES=3 -> 3 writes this frame, 2 in the next frame, in order, none repeated.
REQ-033 No iVS edge with iReq0=1 -> no grants and no writes (macro defined); with the macro undefined -> a write every cycle.
REQ-034 Hold a request over 300 windows -> oMiss_cnt saturates at 255.
REQ-035 Assert reset at window cycle 2 -> all outputs at reset values the next cycle, no oFrame_done, pointer=0.
